// File: rtl/song_recorder_pkg.sv
// rtl/song_recorder_pkg.sv - shared field widths, state encoding and note helpers for the song recorder
package song_recorder_pkg;

  localparam int NOTE_KEY_BITS = 7;
  localparam int OCT_BITS      = 3;
  localparam int NOTE_IDX_BITS = 3;
  localparam int LEN_BITS      = 3;
  localparam int ENTRY_BITS    = OCT_BITS + NOTE_IDX_BITS + LEN_BITS;

  localparam logic [NOTE_IDX_BITS-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_REC  = 2'd1,
    REC_DONE = 2'd2
  } rec_state_t;

  function automatic logic [NOTE_KEY_BITS-1:0] note_onehot(input logic [NOTE_IDX_BITS-1:0] idx);
    logic [NOTE_KEY_BITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NOTE_KEY_BITS; i++)
      if (int'(idx) == i + 1) oh[i] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/song_recorder_rec_buffer.sv
// rtl/song_recorder_rec_buffer.sv - simple dual-port entry RAM with a registered read port
module rec_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - captures played notes, quantises their length and stores song entries
// Optional macro SONG_RECORDER_REST_EN: store long rests as note-0 entries.
module song_recorder
  import song_recorder_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int TICK_DIV   = 1_000_000,
  parameter int UNIT_TICKS = 25,
  parameter int MAX_LEN    = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
  input  logic                       stop,
  input  logic [NOTE_KEY_BITS-1:0]   note_key,
  input  logic [OCT_BITS-1:0]        octave,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [ENTRY_BITS-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       recording,
  output logic                       full,
  output logic [NOTE_KEY_BITS-1:0]   led
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SAT = MAX_LEN * UNIT_TICKS;
  localparam int DW  = $clog2(SAT + 1);
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] DUR_SAT  = DW'(SAT);
  localparam logic [PW-1:0] PRE_TOP  = PW'(TICK_DIV - 1);

  rec_state_t               state;
  logic [PW-1:0]            presc;
  logic [DW-1:0]            dur;
  logic [NOTE_IDX_BITS-1:0] cur_note;
  logic [OCT_BITS-1:0]      cur_oct;
  logic [NOTE_IDX_BITS-1:0] key_idx;
  logic [LEN_BITS-1:0]      len;
  logic                     keep;
  logic                     tick;
  logic                     seg_end;
  logic                     rec_active;
  logic                     commit;

  always_comb begin
    key_idx = REST_NOTE;
    for (int i = NOTE_KEY_BITS - 1; i >= 0; i--)
      if (note_key[i]) key_idx = NOTE_IDX_BITS'(i + 1);
  end

  // len counts how many unit boundaries dur has passed, i.e. ceil(dur/UNIT_TICKS) capped at MAX_LEN.
  always_comb begin
    len = '0;
    for (int k = 0; k < MAX_LEN; k++)
      if (int'(dur) > k * UNIT_TICKS) len = len + LEN_BITS'(1);
    if (len == '0) len = LEN_BITS'(1);
  end

  always_comb begin
    keep = 1'b0;
    if (cur_note == REST_NOTE) begin
`ifdef SONG_RECORDER_REST_EN
      keep = (int'(dur) >= UNIT_TICKS);
`else
      keep = 1'b0;
`endif
    end else begin
      keep = (int'(dur) >= UNIT_TICKS / 2);
    end
  end

  assign full       = (count == FULL_CNT);
  assign tick       = (state == REC_REC) && (presc == PRE_TOP);
  assign seg_end    = (key_idx != cur_note) || (dur == DUR_SAT);
  assign rec_active = (state == REC_REC) && en && !start;
  assign commit     = rec_active && !full && (stop || seg_end) && keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REC_IDLE;
      count     <= '0;
      presc     <= '0;
      dur       <= '0;
      cur_note  <= REST_NOTE;
      cur_oct   <= '0;
      recording <= 1'b0;
      led       <= '0;
    end else if (!en) begin
      state     <= REC_IDLE;
      recording <= 1'b0;
      led       <= '0;
    end else if (start) begin
      state     <= REC_REC;
      count     <= '0;
      presc     <= '0;
      dur       <= '0;
      cur_note  <= key_idx;
      cur_oct   <= octave;
      recording <= 1'b1;
      led       <= note_onehot(key_idx);
    end else if (state == REC_REC) begin
      if (full || stop) begin
        state     <= REC_DONE;
        recording <= 1'b0;
        led       <= '0;
        if (commit) count <= count + 1'b1;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (seg_end) begin
          if (commit) count <= count + 1'b1;
          cur_note <= key_idx;
          cur_oct  <= octave;
          dur      <= '0;
          led      <= note_onehot(key_idx);
        end else if (tick && dur != DUR_SAT) begin
          dur <= dur + DW'(1);
        end
      end
    end
  end

  rec_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .wr_addr (count[AW-1:0]),
    .wr_data ({cur_oct, cur_note, len}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - self-checking bench for song_recorder (small tick/unit/depth settings)
module tb_song_recorder;

  localparam int DEPTH = 4;
  localparam int TDIV  = 2;
  localparam int UNIT  = 4;
  localparam int MAXL  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] note_key = '0;
  logic [2:0] octave = '0;
  logic [1:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic [2:0] count;
  logic       recording;
  logic       full;
  logic [6:0] led;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  song_recorder #(
    .DEPTH(DEPTH), .TICK_DIV(TDIV), .UNIT_TICKS(UNIT), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
    .note_key(note_key), .octave(octave), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .recording(recording), .full(full), .led(led)
  );

  typedef struct {
    logic [6:0] key;
    logic [2:0] oct;
    int         ticks;
    int         cnt;
    logic [8:0] entry;
    logic [6:0] led;
  } vec_t;

  vec_t       tbl[9];
  logic [6:0] sk[$];
  logic [2:0] so[$];
  int         st[$];
  int         si[$];
  logic [8:0] exp_q[$];
  logic [6:0] led_seen;
  logic       rec_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic clear_segs();
    sk.delete(); so.delete(); st.delete(); si.delete();
  endtask

  task automatic add_seg(input int idx, input logic [6:0] extra, input logic [2:0] oct, input int ticks);
    logic [6:0] oh;
    logic [6:0] hi;
    oh = (idx == 0) ? 7'd0 : (7'd1 << (idx - 1));
    hi = (idx == 0) ? 7'd0 : ~((oh << 1) - 7'd1);
    sk.push_back(oh | (extra & hi));
    so.push_back(oct);
    st.push_back(ticks);
    si.push_back(idx);
  endtask

  // Each segment is held for exactly its tick count before the next key (or stop) is applied.
  task automatic play(input bit do_stop);
    @(negedge clk);
    start = 1'b1; note_key = sk[0]; octave = so[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; led_seen = led; rec_seen = recording;
    repeat (2 * st[0]) @(posedge clk);
    for (int i = 1; i < sk.size(); i++) begin
      @(negedge clk);
      note_key = sk[i]; octave = so[i];
      repeat (2 * st[i] + 1) @(posedge clk);
    end
    if (do_stop) begin
      @(negedge clk); stop = 1'b1;
      @(posedge clk);
      @(negedge clk); stop = 1'b0; note_key = '0;
    end
  endtask

  task automatic check_entry(input string name, input logic [1:0] a, input logic [8:0] exp);
    @(negedge clk); rd_addr = a;
    @(negedge clk);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  // Reference: one entry per segment from the commit rules, truncated at DEPTH.
  task automatic model();
    int len;
    bit keep;
    exp_q.delete();
    for (int i = 0; i < si.size(); i++) begin
`ifdef SONG_RECORDER_REST_EN
      keep = (si[i] != 0) ? (st[i] >= UNIT / 2) : (st[i] >= UNIT);
`else
      keep = (si[i] != 0) && (st[i] >= UNIT / 2);
`endif
      len = (st[i] + UNIT - 1) / UNIT;
      if (len > MAXL) len = MAXL;
      if (len < 1) len = 1;
      if (keep && exp_q.size() < DEPTH) exp_q.push_back({so[i], 3'(si[i]), 3'(len)});
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{7'b0000100, 3'd4, 16, 1, 9'b100_011_100, 7'b0000100};
    tbl[1] = '{7'b0000001, 3'd0,  1, 0, 9'd0,           7'b0000001};
    tbl[2] = '{7'b0000001, 3'd1,  2, 1, 9'b001_001_001, 7'b0000001};
    tbl[3] = '{7'b0000110, 3'd2,  5, 1, 9'b010_010_010, 7'b0000010};
    tbl[4] = '{7'b1000000, 3'd7, 28, 1, 9'b111_111_111, 7'b1000000};
    tbl[5] = '{7'b1110000, 3'd3,  9, 1, 9'b011_101_011, 7'b0010000};
`ifdef SONG_RECORDER_REST_EN
    tbl[6] = '{7'b0000000, 3'd5,  8, 1, 9'b101_000_010, 7'b0000000};
`else
    tbl[6] = '{7'b0000000, 3'd5,  8, 0, 9'd0,           7'b0000000};
`endif
    tbl[7] = '{7'b0101000, 3'd6,  4, 1, 9'b110_100_001, 7'b0001000};
    tbl[8] = '{7'b0000001, 3'd0,  3, 1, 9'b000_001_001, 7'b0000001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count", 32'(count), 32'd0);
    check("reset_recording", 32'(recording), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1; en = 1'b1;

    for (int v = 0; v < 9; v++) begin
      sk.delete(); so.delete(); st.delete(); si.delete();
      sk.push_back(tbl[v].key); so.push_back(tbl[v].oct); st.push_back(tbl[v].ticks);
      play(1'b1);
      check($sformatf("vec%0d_led", v), 32'(led_seen), 32'(tbl[v].led));
      check($sformatf("vec%0d_rec", v), 32'(rec_seen), 32'd1);
      check($sformatf("vec%0d_count", v), 32'(count), 32'(tbl[v].cnt));
      check($sformatf("vec%0d_done", v), 32'(recording), 32'd0);
      if (tbl[v].cnt != 0) check_entry($sformatf("vec%0d_entry", v), 2'd0, tbl[v].entry);
    end

    clear_segs();
    add_seg(1, 7'd0, 3'd4, 1); add_seg(2, 7'd0, 3'd4, 8);
    play(1'b1);
    check("glitch_count", 32'(count), 32'd1);
    check_entry("glitch_entry", 2'd0, 9'b100_010_010);

    clear_segs();
    add_seg(7, 7'd0, 3'd6, 40);
    play(1'b1);
    check("sat_count", 32'(count), 32'd2);
    check_entry("sat_entry0", 2'd0, 9'b110_111_111);
    check_entry("sat_entry1", 2'd1, 9'b110_111_011);

    clear_segs();
    for (int i = 1; i <= 5; i++) add_seg(i, 7'd0, 3'd2, 4);
    play(1'b1);
    check("full_count", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("full_done", 32'(recording), 32'd0);
    for (int a = 0; a < 4; a++)
      check_entry($sformatf("full_entry%0d", a), 2'(a), {3'd2, 3'(a + 1), 3'd1});
    check("full_held", 32'(full), 32'd1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("full_clear_on_start", 32'(full), 32'd0);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    clear_segs();
    add_seg(1, 7'd0, 3'd3, 4); add_seg(0, 7'd0, 3'd5, 8); add_seg(3, 7'd0, 3'd3, 4);
    play(1'b1);
`ifdef SONG_RECORDER_REST_EN
    check("rest_count", 32'(count), 32'd3);
    check_entry("rest_entry1", 2'd1, 9'b101_000_010);
    check_entry("rest_entry2", 2'd2, 9'b011_011_001);
`else
    check("rest_count", 32'(count), 32'd2);
    check_entry("rest_entry1", 2'd1, 9'b011_011_001);
`endif

    clear_segs();
    add_seg(1, 7'd0, 3'd1, 4); add_seg(2, 7'd0, 3'd1, 4); add_seg(3, 7'd0, 3'd1, 4);
    play(1'b0);
    check("prereset_count", 32'(count), 32'd2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_recording", 32'(recording), 32'd0);
    check("midreset_full", 32'(full), 32'd0);
    check("midreset_led", 32'(led), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    clear_segs();
    add_seg(4, 7'd0, 3'd5, 8);
    play(1'b1);
    check("postreset_count", 32'(count), 32'd1);
    check_entry("postreset_entry0", 2'd0, 9'b101_100_010);

    clear_segs();
    add_seg(5, 7'd0, 3'd2, 4); add_seg(6, 7'd0, 3'd2, 4); add_seg(1, 7'd0, 3'd2, 4);
    play(1'b0);
    clear_segs();
    add_seg(2, 7'd0, 3'd7, 4);
    play(1'b1);
    check("restart_count", 32'(count), 32'd1);
    check_entry("restart_entry0", 2'd0, 9'b111_010_001);

    @(negedge clk); en = 1'b0;
    @(negedge clk);
    check("disable_count_kept", 32'(count), 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("disable_start_ignored", 32'(recording), 32'd0);
    check_entry("disable_read", 2'd0, 9'b111_010_001);
    en = 1'b1;

    for (int r = 0; r < 16; r++) begin
      int nseg;
      int prev;
      int idx;
      clear_segs();
      nseg = $urandom_range(1, 6);
      prev = -1;
      for (int s = 0; s < nseg; s++) begin
        do idx = $urandom_range(0, 7); while (idx == prev);
        prev = idx;
        add_seg(idx, 7'($urandom), 3'($urandom), $urandom_range(1, 28));
      end
      play(1'b1);
      model();
      check($sformatf("rand%0d_count", r), 32'(count), 32'(exp_q.size()));
      check($sformatf("rand%0d_full", r), 32'(full), 32'(exp_q.size() == DEPTH));
      for (int a = 0; a < exp_q.size(); a++)
        check_entry($sformatf("rand%0d_entry%0d", r, a), 2'(a), exp_q[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Writer side of the song-memory interface: captures notes played on the note keys, quantises each note to the length code used by the song player, and stores {octave, note, length} entries in an internal buffer.
- The auto/play path reads the buffer back through a synchronous read port, the same way it consumes built-in songs.
- Instantiated beside the free-mode block in the top-level controller and driven by the same key, octave and submit/cancel pulse signals.

Parameters:
- DEPTH, 64: number of stored entries; must be a power of two.
- TICK_DIV, 1_000_000: clk cycles per time tick (10 ms at 100 MHz).
- UNIT_TICKS, 25: ticks per length unit (250 ms).
- MAX_LEN, 7: largest length code; fixed by the 3-bit length field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  block enabled (recorder mode selected); low forces IDLE
- start  in  1  single-cycle pulse: clear the buffer and begin recording
- stop  in  1  single-cycle pulse: end recording
- note_key  in  7  raw note keys, bit0 = do ... bit6 = ti
- octave  in  3  current octave, sampled at note onset
- rd_addr  in  log2(DEPTH)  playback read address
- rd_data  out  9  {octave[2:0], note[2:0], len[2:0]}; note 0 = rest
- count  out  log2(DEPTH)+1  number of valid entries
- recording  out  1  high in REC
- full  out  1  high when count == DEPTH
- led  out  7  echo of the currently captured key, one-hot

Behaviour:
- Reset: all outputs 0; state IDLE; count 0; tick and duration counters 0; rd_data 0. Buffer contents are not reset.
- Key encoding: priority encoder over note_key, lowest set bit wins. Index is 1..7; 0 means no key (rest).
- Time base: prescaler counts 0..TICK_DIV-1 and pulses tick on wrap. It runs only in REC and clears on entry to REC.
- States:
  - IDLE: waits for en & start.
  - REC: capturing notes.
  - DONE: holds the buffer for playback.
- Transitions:
  - IDLE/DONE -> REC on en & start. count <= 0; cur_note <= current encoded key; cur_oct <= octave; dur <= 0.
  - REC -> DONE on stop or full. The pending segment is flushed first (see commit rules).
  - Any state -> IDLE when en = 0. count is kept, so the buffer stays readable.
- Segment tracking in REC:
  - dur increments on each tick and saturates at MAX_LEN*UNIT_TICKS.
  - A segment ends when the encoded key differs from cur_note, or when dur reaches saturation; in the saturation case a new segment continues with the same note.
  - On segment end, commit an entry, then load cur_note/cur_oct from the present inputs and set dur <= 0, all in the same cycle.
- Commit rules:
  - len = min(MAX_LEN, ceil(dur/UNIT_TICKS)).
  - A note segment with dur < UNIT_TICKS/2 is a glitch and is dropped.
  - Otherwise len is raised to at least 1; write mem[count] <= {cur_oct, cur_note, len} and increment count.
- Writes: one per cycle at most. Write latency is 1 cycle from the segment-end cycle.
- Full buffer:
  - When count == DEPTH, the commit is suppressed and the state goes to DONE.
  - full stays high until the next start.
  - No wrap-around and no overwrite.
- Simultaneous stop and key change: commit once, then go to DONE.
- start while in REC: restarts recording and discards the pending segment.
- start and stop together: start wins.
- Read port: rd_data <= mem[rd_addr] one cycle after rd_addr; usable in every state.
- Reads during REC return committed entries only. A read and a write to the same address in one cycle returns old data.
- Reset mid-recording: immediate return to IDLE with count 0. A partial entry is never written.
- led = one-hot of cur_note while in REC, 0 otherwise.

Optional Feature:
- Macro: SONG_RECORDER_REST_EN
- Defined: rest segments (cur_note = 0) with dur >= UNIT_TICKS are committed with note 0. A rest of this length is recorded as an entry even right after start.
- Not defined: rest segments are never stored, and the held time of a rest is discarded. Playback is then legato.

Decomposition:
- Shared constants header:
  - NOTE_KEY_BITS = 7
  - field widths: OCT_BITS = 3, NOTE_IDX_BITS = 3, LEN_BITS = 3
  - ENTRY_BITS = 9
  - state encodings REC_IDLE, REC_REC, REC_DONE
  - REST_NOTE = 0
- One natural sub-module: rec_buffer, a simple dual-port RAM (DEPTH x ENTRY_BITS) with a synchronous read port. The FSM, prescaler and quantiser stay in song_recorder.

Test Plan (TICK_DIV = 2, UNIT_TICKS = 4, DEPTH = 4):
- Press key bit2 at octave 4 for 16 ticks, release, then stop -> one entry 9'b100_011_100; count = 1; state DONE.
- Press key bit0 for 1 tick (glitch), then key bit1 for 8 ticks, then stop -> only {4,2,2} stored; count = 1.
- Hold key bit6 for 40 ticks -> entries {o,7,7} and {o,7,3} on stop; the split happens at the saturation of 28 ticks.
- Record 5 notes of 4 ticks each -> count = 4; full = 1; state DONE after the 4th commit; the 5th is absent. Read addresses 0..3 return the 4 entries one cycle after each address.
- 8-tick rest between two notes -> with SONG_RECORDER_REST_EN, count = 3 and entry 1 = {o,0,2}; without the macro, count = 2.
- Deassert rst_n during REC after 2 commits -> count = 0, recording = 0, full = 0 immediately; a start after reset records from address 0.
